// File: rtl/demux_sel.sv
// Registered 1-to-4 demultiplexer with per-channel one-entry buffers and valid/ready handshaking.
// Supports addressed writes and all-channel broadcast; counts accepted input words modulo 256.
module demux_sel #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    input  logic               in_bcast,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [7:0]         xfer_cnt
);

    logic [3:0][WIDTH-1:0] data_q, data_d;
    logic [3:0]            valid_q, valid_d;
    logic [7:0]            cnt_q, cnt_d;

    logic [3:0] can_acc;
    logic [3:0] pop;
    logic [3:0] target;
    logic [3:0] push;
    logic       accept;

    always_comb begin
        can_acc  = ~valid_q | out_ready;
        pop      = valid_q & out_ready;
        // A broadcast needs every channel free so it is never partially delivered.
        in_ready = in_bcast ? (&can_acc) : can_acc[in_sel];
        accept   = in_valid & in_ready;
        target   = in_bcast ? 4'b1111 : (4'b0001 << in_sel);
        push     = accept ? target : 4'b0000;
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        for (int unsigned k = 0; k < 4; k++) begin
            if (push[k]) begin
                data_d[k]  = in_data;
                valid_d[k] = 1'b1;
            end else if (pop[k]) begin
                valid_d[k] = 1'b0;
            end
        end
        if (accept) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= '0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_demux_sel.sv
// Directed bench for demux_sel: a per-channel expected-word queue and shadow data/counter
// model are advanced every cycle and compared against the DUT outputs.
module tb_demux_sel;

    localparam int unsigned WIDTH = 4;

    logic               clk;
    logic               rst;
    logic [WIDTH-1:0]   in_data;
    logic [1:0]         in_sel;
    logic               in_bcast;
    logic               in_valid;
    logic               in_ready;
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [7:0]         xfer_cnt;

    demux_sel #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_bcast  (in_bcast),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .xfer_cnt  (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_total  = 0;
    int unsigned n_passed = 0;

    logic [WIDTH-1:0] exp_q [4][$];
    logic [WIDTH-1:0] mdata [4];
    logic [7:0]       mcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic model_ready();
        logic [3:0] can;
        for (int k = 0; k < 4; k++) can[k] = (exp_q[k].size() == 0) | out_ready[k];
        return in_bcast ? (&can) : can[in_sel];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            exp_q[k].delete();
            mdata[k] = '0;
        end
        mcnt = '0;
    endtask

    task automatic check_all();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("valid%0d", k), {31'b0, out_valid[k]}, {31'b0, exp_q[k].size() != 0});
            chk($sformatf("data%0d", k), {28'b0, out_data[k*WIDTH +: WIDTH]}, {28'b0, mdata[k]});
        end
        chk("in_ready", {31'b0, in_ready}, {31'b0, model_ready()});
        chk("xfer_cnt", {24'b0, xfer_cnt}, {24'b0, mcnt});
    endtask

    // Compare at the falling edge, then apply this cycle's handshake to the model.
    task automatic tick();
        logic       rdy;
        logic [3:0] tgt;
        @(negedge clk);
        check_all();
        rdy = model_ready();
        for (int k = 0; k < 4; k++)
            if (exp_q[k].size() != 0 && out_ready[k]) void'(exp_q[k].pop_front());
        if (in_valid && rdy) begin
            tgt = in_bcast ? 4'b1111 : (4'b0001 << in_sel);
            for (int k = 0; k < 4; k++) begin
                if (tgt[k]) begin
                    exp_q[k].push_back(in_data);
                    mdata[k] = in_data;
                end
            end
            mcnt = mcnt + 8'd1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    logic [1:0] sel_tab [4];

    initial begin
        sel_tab[0] = 2'd0; sel_tab[1] = 2'd1; sel_tab[2] = 2'd3; sel_tab[3] = 2'd2;
        rst = 1'b1; in_data = '0; in_sel = '0; in_bcast = 1'b0; in_valid = 1'b0; out_ready = 4'b0000;
        model_reset();
        @(negedge clk);
        check_all();
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset mid-transfer with channel 2 holding 7
        in_valid = 1'b1; in_sel = 2'd2; in_data = 4'd7;
        tick();
        in_valid = 1'b0;
        tick();
        chk("ch2_before_rst", {28'b0, out_data[2*WIDTH +: WIDTH]}, 32'h7);
        in_valid = 1'b1; in_sel = 2'd2; in_data = 4'd3;
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", {28'b0, out_valid}, 32'h0);
        chk("rst_data", {16'b0, out_data}, 32'h0);
        chk("rst_cnt", {24'b0, xfer_cnt}, 32'h0);
        chk("rst_ready", {31'b0, in_ready}, 32'h1);
        in_bcast = 1'b1; #1;
        chk("rst_ready_bcast", {31'b0, in_ready}, 32'h1);
        in_valid = 1'b0; in_bcast = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;

        // Addressed writes with all consumers ready
        out_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_sel = sel_tab[i]; in_data = 4'(i + 1);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("addr_cnt", {24'b0, xfer_cnt}, 32'd4);

        // Backpressure on channel 1, channel 3 stays independent
        out_ready = 4'b1101;
        in_valid = 1'b1; in_sel = 2'd1; in_data = 4'd5;
        tick();
        in_sel = 2'd3; in_data = 4'd9; #0;
        chk("ind_ready", {31'b0, in_ready}, 32'h1);
        tick();
        chk("ind_ch3_data", {28'b0, out_data[3*WIDTH +: WIDTH]}, 32'h9);
        chk("ind_ch1_data", {28'b0, out_data[1*WIDTH +: WIDTH]}, 32'h5);
        chk("ind_valid", {28'b0, out_valid}, 32'b1010);
        in_sel = 2'd1; in_data = 4'd6; #0;
        chk("bp_ready", {31'b0, in_ready}, 32'h0);
        tick();
        tick();
        chk("bp_hold", {28'b0, out_data[1*WIDTH +: WIDTH]}, 32'h5);
        out_ready = 4'b1111; #0;
        chk("bp_release_ready", {31'b0, in_ready}, 32'h1);
        tick();
        in_valid = 1'b0;
        chk("bp_ch1_data", {28'b0, out_data[1*WIDTH +: WIDTH]}, 32'h6);
        chk("bp_ch1_valid", {31'b0, out_valid[1]}, 32'h1);
        chk("bp_cnt", {24'b0, xfer_cnt}, 32'd7);
        tick();

        // Broadcast blocked by full channel 0
        out_ready = 4'b1110;
        in_valid = 1'b1; in_sel = 2'd0; in_data = 4'd3;
        tick();
        in_bcast = 1'b1; in_sel = 2'd2; in_data = 4'hA; #0;
        chk("bc_block_ready", {31'b0, in_ready}, 32'h0);
        tick();
        tick();
        chk("bc_block_ch0", {28'b0, out_data[0*WIDTH +: WIDTH]}, 32'h3);
        chk("bc_block_cnt", {24'b0, xfer_cnt}, 32'd8);
        out_ready = 4'b1111;
        tick();
        in_valid = 1'b0; in_bcast = 1'b0;
        chk("bc_data", {16'b0, out_data}, 32'hAAAA);
        chk("bc_valid", {28'b0, out_valid}, 32'hF);
        chk("bc_cnt", {24'b0, xfer_cnt}, 32'd9);
        tick();

        // Counter wrap after 256 words from a fresh reset
        rst = 1'b1; #1;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 4'b1111;
        for (int i = 0; i < 256; i++) begin
            in_valid = 1'b1; in_sel = 2'(i); in_data = 4'(i);
            tick();
        end
        chk("wrap_cnt", {24'b0, xfer_cnt}, 32'd0);
        out_ready = 4'b0000;
        in_sel = 2'd3; in_data = 4'hF; #0;
        chk("held_ready", {31'b0, in_ready}, 32'h0);
        tick();
        tick();
        tick();
        chk("held_cnt", {24'b0, xfer_cnt}, 32'd0);
        chk("held_ch3", {28'b0, out_data[3*WIDTH +: WIDTH]}, 32'hF);
        in_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
